// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared run-control state encoding
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } run_state_t;

    localparam logic [1:0] STATE_HALT  = 2'd0;
    localparam logic [1:0] STATE_RUN   = 2'd1;
    localparam logic [1:0] STATE_STEP  = 2'd2;
    localparam logic [1:0] STATE_BREAK = 2'd3;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - active-low key synchronizer, debouncer and press pulse
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          level_prev_q, level_prev_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d      = key_n_i;
        sync2_d      = sync1_q;
        level_d      = level_q;
        cnt_d        = '0;
        level_prev_d = level_q;
        // Any sample that agrees with the accepted level restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        press_d = level_prev_q & ~level_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - core clock-enable sequencer with step, breakpoint and cycle counter
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ADDR_W          = 32,
    parameter int CNT_W           = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run_mode_i,
    input  logic              step_key_n_i,
    input  logic              bp_en_i,
    input  logic [ADDR_W-1:0] bp_addr_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              cnt_clr_i,
    output logic              cpu_en_o,
    output logic [1:0]        state_o,
    output logic              halted_o,
    output logic              bp_hit_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);

    run_state_t       state_q, state_d;
    logic             run_s1_q, run_s1_d;
    logic             run_s2_q, run_s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press;
    logic             bp_match;
    logic             cpu_en;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_key (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n_i (step_key_n_i),
        .press_o (press)
    );

    assign bp_match = bp_en_i && (pc_i == bp_addr_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_HALT;
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            run_s1_q <= run_s1_d;
            run_s2_q <= run_s2_d;
            cnt_q    <= cnt_d;
        end
    end

    // Run request beats a coincident press in HALT; the press is simply lost.
    always_comb begin
        run_s1_d = run_mode_i;
        run_s2_d = run_s1_q;
        state_d  = state_q;
        unique case (state_q)
            ST_HALT: begin
                if (run_s2_q)   state_d = ST_RUN;
                else if (press) state_d = ST_STEP;
            end
            ST_RUN: begin
                if (!run_s2_q)     state_d = ST_HALT;
                else if (bp_match) state_d = ST_BREAK;
            end
            ST_STEP: state_d = ST_HALT;
            ST_BREAK: begin
                if (!run_s2_q)  state_d = ST_HALT;
                else if (press) state_d = ST_STEP;
            end
            default: state_d = ST_HALT;
        endcase
    end

    // The breakpoint compare gates the enable combinationally so the
    // matching instruction never executes while running.
    always_comb begin
        cpu_en   = (state_q == ST_STEP) || ((state_q == ST_RUN) && !bp_match);
        halted_o = (state_q == ST_HALT) || (state_q == ST_BREAK);
        bp_hit_o = (state_q == ST_BREAK);
        if (cnt_clr_i)   cnt_d = '0;
        else if (cpu_en) cnt_d = cnt_q + CNT_W'(1);
        else             cnt_d = cnt_q;
    end

    assign cpu_en_o    = cpu_en;
    assign state_o     = state_q;
    assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - self-checking bench for run_ctrl
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run_mode_i;
    logic        step_key_n_i;
    logic        bp_en_i;
    logic [31:0] bp_addr_i;
    logic [31:0] pc_i;
    logic        cnt_clr_i;
    logic        cpu_en_o;
    logic [1:0]  state_o;
    logic        halted_o;
    logic        bp_hit_o;
    logic [7:0]  cycle_cnt_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0;
    logic mon_en = 1'b0;
    int exp_q[$];

    typedef struct {
        logic        bp_en;
        logic [31:0] bp_addr;
        logic [31:0] pc;
        logic        exp_en;
    } bp_vec_t;

    bp_vec_t vecs[6];

    run_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .ADDR_W(32),
        .CNT_W(8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .run_mode_i   (run_mode_i),
        .step_key_n_i (step_key_n_i),
        .bp_en_i      (bp_en_i),
        .bp_addr_i    (bp_addr_i),
        .pc_i         (pc_i),
        .cnt_clr_i    (cnt_clr_i),
        .cpu_en_o     (cpu_en_o),
        .state_o      (state_o),
        .halted_o     (halted_o),
        .bp_hit_o     (bp_hit_o),
        .cycle_cnt_o  (cycle_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each expected enable pulse carries the cycle it must appear in.
    always @(negedge clk) begin
        if (mon_en && cpu_en_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_en_cycle", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                check("step_en_cycle", 32'(cyc), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        vecs[0] = '{1'b1, 32'h40, 32'h34, 1'b1};
        vecs[1] = '{1'b1, 32'h40, 32'h38, 1'b1};
        vecs[2] = '{1'b1, 32'h40, 32'h3C, 1'b1};
        vecs[3] = '{1'b0, 32'h40, 32'h40, 1'b1};
        vecs[4] = '{1'b1, 32'h41, 32'h40, 1'b1};
        vecs[5] = '{1'b1, 32'h40, 32'h40, 1'b0};

        reset_n = 1'b0; run_mode_i = 1'b0; step_key_n_i = 1'b1;
        bp_en_i = 1'b0; bp_addr_i = '0; pc_i = '0; cnt_clr_i = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_halted", 32'(halted_o), 32'd1);
        check("rst_en", 32'(cpu_en_o), 32'd0);
        check("rst_cnt", 32'(cycle_cnt_o), 32'd0);
        check("rst_bp_hit", 32'(bp_hit_o), 32'd0);

        // Held key: one step at t+8.
        tick();
        mon_en = 1'b1;
        t0 = cyc;
        step_key_n_i = 1'b0;
        exp_q.push_back(t0 + 8);
        repeat (20) tick();
        step_key_n_i = 1'b1;
        repeat (12) tick();
        check("step_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("step_cnt", 32'(cycle_cnt_o), 32'd1);
        check("step_state", 32'(state_o), 32'd0);

        // Bounce 0-1-0 of two cycles each: no pulse.
        tick();
        step_key_n_i = 1'b0; repeat (2) tick();
        step_key_n_i = 1'b1; repeat (2) tick();
        step_key_n_i = 1'b0; repeat (2) tick();
        step_key_n_i = 1'b1; repeat (12) tick();
        @(negedge clk);
        check("glitch_cnt", 32'(cycle_cnt_o), 32'd1);
        mon_en = 1'b0;

        // Free run for 300 cycles then clear.
        tick();
        run_mode_i = 1'b1;
        for (int i = 0; i <= 310; i++) begin
            if (i == 300) run_mode_i = 1'b0;
            @(negedge clk);
            check($sformatf("run_en_%0d", i), 32'(cpu_en_o), 32'((i >= 3 && i < 303) ? 1 : 0));
            if (i == 302) check("run_state_before_halt", 32'(state_o), 32'd1);
            if (i == 303) check("run_state_halt", 32'(state_o), 32'd0);
            tick();
        end
        @(negedge clk);
        check("run_cnt_wrap", 32'(cycle_cnt_o), 32'(8'(1 + 300)));

        // Breakpoint vectors while running.
        tick();
        run_mode_i = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        check("bp_pre_run", 32'(state_o), 32'd1);
        tick();
        for (int i = 0; i < 6; i++) begin
            bp_en_i = vecs[i].bp_en; bp_addr_i = vecs[i].bp_addr; pc_i = vecs[i].pc;
            @(negedge clk);
            check($sformatf("bp_vec_%0d_en", i), 32'(cpu_en_o), 32'(vecs[i].exp_en));
            tick();
        end
        @(negedge clk);
        check("bp_state", 32'(state_o), 32'd3);
        check("bp_hit", 32'(bp_hit_o), 32'd1);
        check("bp_halted", 32'(halted_o), 32'd1);
        check("bp_en_off", 32'(cpu_en_o), 32'd0);

        // Step over the breakpoint, then RUN resumes.
        tick();
        mon_en = 1'b1;
        t0 = cyc;
        step_key_n_i = 1'b0;
        pc_i = 32'h44;
        exp_q.push_back(t0 + 8);
        repeat (9) tick();
        mon_en = 1'b0;
        @(negedge clk);
        check("bp_step_pending", 32'(exp_q.size()), 32'd0);
        check("bp_after_step", 32'(state_o), 32'd0);
        @(negedge clk);
        check("bp_resume_state", 32'(state_o), 32'd1);
        check("bp_resume_en", 32'(cpu_en_o), 32'd1);
        step_key_n_i = 1'b1;

        // Counter clear while running.
        tick();
        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i = 1'b0;
        @(negedge clk);
        check("clr_cnt_zero", 32'(cycle_cnt_o), 32'd0);
        @(negedge clk);
        check("clr_cnt_next", 32'(cycle_cnt_o), 32'd1);

        // Run and press reach the FSM in the same cycle.
        tick();
        run_mode_i = 1'b0;
        bp_en_i = 1'b0;
        repeat (12) tick();
        @(negedge clk);
        check("both_pre_halt", 32'(state_o), 32'd0);
        tick();
        step_key_n_i = 1'b0;
        repeat (5) tick();
        run_mode_i = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("both_still_halt", 32'(state_o), 32'd0);
        tick();
        @(negedge clk);
        check("both_run", 32'(state_o), 32'd1);
        @(negedge clk);
        check("both_no_step", 32'(state_o), 32'd1);
        check("both_en", 32'(cpu_en_o), 32'd1);
        run_mode_i = 1'b0;
        step_key_n_i = 1'b1;
        repeat (12) tick();

        // Reset in the middle of a step.
        step_key_n_i = 1'b0;
        repeat (8) tick();
        #2;
        check("rststep_en_before", 32'(cpu_en_o), 32'd1);
        check("rststep_state_before", 32'(state_o), 32'd2);
        reset_n = 1'b0;
        #1;
        check("rststep_en", 32'(cpu_en_o), 32'd0);
        check("rststep_state", 32'(state_o), 32'd0);
        check("rststep_cnt", 32'(cycle_cnt_o), 32'd0);
        check("rststep_halted", 32'(halted_o), 32'd1);
        step_key_n_i = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("post_rst_state", 32'(state_o), 32'd0);
        check("post_rst_cnt", 32'(cycle_cnt_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Execution controller that sequences the processor core's clock enable on the DE1-SoC board. Provides free-run, halt, single-step (from a debounced push-button) and PC breakpoint modes, plus an executed-cycle counter. Sits between the board inputs (SW, KEY) and the core's clock-enable input. The whole design stays on one clock; the core no longer runs from a raw key-driven clock.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable cycles the key must hold before a change is accepted (10 ms at 50 MHz).
- `ADDR_W`, default 32: width of the PC and breakpoint address.
- `CNT_W`, default 32: width of the cycle counter.

Ports:
- `clk` in 1: system clock, CLOCK_50.
- `reset_n` in 1: asynchronous, active-low reset.
- `run_mode_i` in 1: run request, a level from SW. Asynchronous to `clk`.
- `step_key_n_i` in 1: step push-button from KEY, active-low. Asynchronous and bouncy.
- `bp_en_i` in 1: breakpoint enable.
- `bp_addr_i` in ADDR_W: breakpoint address.
- `pc_i` in ADDR_W: current core PC.
- `cnt_clr_i` in 1: synchronous clear of the cycle counter.
- `cpu_en_o` out 1: clock enable to the core.
- `state_o` out 2: current FSM state.
- `halted_o` out 1: high in HALT or BREAK.
- `bp_hit_o` out 1: high in BREAK.
- `cycle_cnt_o` out CNT_W: number of cycles with `cpu_en_o` high.

## Operation

Input conditioning:
- Each of `run_mode_i` and `step_key_n_i` passes through a 2-flop synchronizer.
- Synchronizer reset values: 0 for run mode, 1 (released) for the key.

Key debouncer:
- Holds an accepted level, reset value 1.
- Its counter increments while the synchronized key differs from the accepted level. It resets to 0 whenever the two are equal.
- When the counter reaches `DEBOUNCE_CYCLES-1` and the levels still differ, the accepted level takes the new value.
- An accepted 1→0 transition produces a registered one-cycle `press` pulse.

FSM states: HALT=0, RUN=1, STEP=2, BREAK=3. Reset state is HALT.
- HALT → RUN if `run_mode` is set. Otherwise → STEP on `press`. If both occur in the same cycle, RUN wins and the press is discarded.
- STEP → HALT unconditionally after one cycle. No breakpoint check is made in STEP, so a step always executes the instruction at `pc_i`.
- RUN → HALT if `run_mode` is 0. Otherwise → BREAK if `bp_en_i` is set and `pc_i==bp_addr_i`.
- BREAK → HALT if `run_mode` is 0. Otherwise → STEP on `press`, which steps over the breakpoint; HALT then re-enters RUN.
- `press` is ignored in RUN and STEP.

Outputs:
- `cpu_en_o` is high in STEP.
- In RUN, `cpu_en_o` = !(`bp_en_i` && `pc_i`==`bp_addr_i`). The compare is combinational, so the breakpoint instruction is never executed in RUN.
- `cpu_en_o` is 0 in HALT and BREAK.
- Cycle counter increments on every cycle `cpu_en_o`=1 and wraps modulo 2^CNT_W.
- `cnt_clr_i` takes priority over increment. The counter reads 0 on the next cycle.

Reset values: `cpu_en_o`=0, `state_o`=0, `halted_o`=1, `bp_hit_o`=0, `cycle_cnt_o`=0.

Reset mid-operation:
- Asserting `reset_n` low immediately forces HALT and zeroes all counters, even in the middle of a step.
- The debouncer restarts from the released state.

## Timing

- Key falling edge first sampled at clk edge t:
  - synchronized at t+2;
  - accepted level changes at t+2+DEBOUNCE_CYCLES;
  - `press` at t+3+DEBOUNCE_CYCLES;
  - `cpu_en_o` high for exactly one cycle at t+4+DEBOUNCE_CYCLES.
- A held key produces exactly one step. A key glitch shorter than DEBOUNCE_CYCLES produces no step.
- Run switch: RUN entered 3 cycles after the input change is sampled. Leaving RUN also takes 3 cycles; `cpu_en_o` drops in the same cycle the state becomes HALT.
- Breakpoint: `cpu_en_o` drops in the same cycle `pc_i` matches. BREAK is entered on the next edge.

## Structure

- Package `run_ctrl_pkg`: state typedef `run_state_t` (2-bit enum, encodings above) and the state encoding constants, shared with the debug/HEX display logic.
- Sub-module `key_debounce`: synchronizer, debounce counter, accepted level and falling-edge pulse, parameterised by DEBOUNCE_CYCLES. Reused for the other KEYs.
- `run_ctrl` contains the FSM, the breakpoint compare and the cycle counter.

## Test plan

Sim parameters: DEBOUNCE_CYCLES=4, CNT_W=8.
- Reset, then idle 10 cycles → `state_o`=0, `halted_o`=1, `cpu_en_o`=0, `cycle_cnt_o`=0.
- In HALT, key low held for 20 cycles → exactly one `cpu_en_o` pulse at t+8, `cycle_cnt_o`=1, state returns to 0. A key bounce of 0-1-0 pulses of 2 cycles each → no pulse.
- Run switch set for 300 cycles, then cleared → `cpu_en_o` high throughout RUN. `cycle_cnt_o` wraps past 255 to the expected value modulo 256; the core halts 3 cycles after the clear.
- `bp_en_i`=1, `bp_addr_i`=0x40, RUN with `pc_i` ramping → `cpu_en_o`=0 in the cycle `pc_i`=0x40, then `state_o`=3 and `bp_hit_o`=1. A key press gives one enable pulse, then RUN resumes.
- In HALT, run set and press in the same cycle → RUN, with no extra STEP. `cnt_clr_i` while running → counter reads 0 on the next cycle.
- `reset_n` asserted during STEP → `cpu_en_o` drops immediately, state 0, counter 0.
